dense_output_streamer: RTL and testbench

//  Output-side buffer for a dense layer: the dense datapath writes OUT_COUNT results by address,

---
 rtl/dense_output_streamer.sv | 116 +++++++++++
 tb/tb_dense_output_streamer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dense_output_streamer.sv
// dense_output_streamer: buffers dense-layer results by address and streams them out as one AXI4-Stream frame.
// Optional DENSE_OUT_ARGMAX_EN appends a beat carrying the index of the largest signed word.
module dense_output_streamer #(
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bufferOut_we,
  input  logic [$clog2(OUT_COUNT)-1:0] bufferOut_adr,
  input  logic [DATA_SIZE-1:0]         bufferOut_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         overrun,
  output logic                         done,
  output logic [DATA_SIZE-1:0]         m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);
  localparam int AW = $clog2(OUT_COUNT);
  localparam logic [AW-1:0] LAST = AW'(OUT_COUNT - 1);
  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef DENSE_OUT_ARGMAX_EN
    , SEND_IDX
`endif
  } state_t;
  state_t state_q, state_d;
  logic [DATA_SIZE-1:0] mem_q [OUT_COUNT];
  logic [DATA_SIZE-1:0] mem_d [OUT_COUNT];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic overrun_q, overrun_d, done_q, done_d;
  logic xfer, last_data;
  assign busy = state_q != IDLE;
  assign overrun = overrun_q;
  assign done = done_q;
  assign m_axis_tvalid = busy;
  assign xfer = m_axis_tvalid & m_axis_tready;
  assign last_data = state_q == SEND && rd_ptr_q == LAST;
`ifdef DENSE_OUT_ARGMAX_EN
  logic signed [DATA_SIZE-1:0] max_q, max_d;
  logic [AW-1:0] idx_q, idx_d;
  assign m_axis_tdata = state_q == SEND_IDX ? {{(DATA_SIZE-AW){1'b0}}, idx_q} :
                        state_q == SEND ? mem_q[rd_ptr_q] : '0;
  assign m_axis_tlast = state_q == SEND_IDX;
  // Strictly-greater update keeps the lower index on ties.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (state_q == IDLE && start) begin
      max_d = {1'b1, {(DATA_SIZE-1){1'b0}}};
      idx_d = '0;
    end else if (state_q == SEND && xfer && $signed(mem_q[rd_ptr_q]) > max_q) begin
      max_d = $signed(mem_q[rd_ptr_q]);
      idx_d = rd_ptr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end
`else
  assign m_axis_tdata = busy ? mem_q[rd_ptr_q] : '0;
  assign m_axis_tlast = last_data;
`endif
  always_comb begin
    state_d = state_q;
    rd_ptr_d = rd_ptr_q;
    overrun_d = overrun_q;
    done_d = 1'b0;
    mem_d = mem_q;
    if (state_q == IDLE) begin
      if (bufferOut_we && int'(bufferOut_adr) < OUT_COUNT) mem_d[bufferOut_adr] = bufferOut_data;
      if (start) begin
        state_d = SEND;
        rd_ptr_d = '0;
        overrun_d = 1'b0;
      end
    end else begin
      if (bufferOut_we) overrun_d = 1'b1;
      if (xfer) begin
        if (state_q == SEND && !last_data) rd_ptr_d = rd_ptr_q + AW'(1);
`ifdef DENSE_OUT_ARGMAX_EN
        else if (last_data) state_d = SEND_IDX;
`endif
        else begin
          state_d = IDLE;
          rd_ptr_d = '0;
          done_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_ptr_q <= '0;
      overrun_q <= 1'b0;
      done_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      overrun_q <= overrun_d;
      done_q <= done_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_dense_output_streamer.sv
// tb_dense_output_streamer: randomized frames checked against an array/queue model of the buffer.
module tb_dense_output_streamer;
  localparam int OC = 10;
  localparam int DW = 32;
  logic clk = 0, rst, we, start, busy, overrun, done, tvalid, tready, tlast;
  logic [3:0] adr;
  logic [DW-1:0] data, tdata;
  logic [DW-1:0] mdl [OC];
  int checks = 0, errors = 0;
  dense_output_streamer #(.OUT_COUNT(OC), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst), .bufferOut_we(we), .bufferOut_adr(adr), .bufferOut_data(data),
    .start(start), .busy(busy), .overrun(overrun), .done(done), .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic wr(input int a, input logic [DW-1:0] d);
    we = 1; adr = a[3:0]; data = d;
    if (a < OC) mdl[a] = d;
    @(negedge clk);
    we = 0;
  endtask
  task automatic frame(input int mode, input int wr_beat, input int rst_beat, input bit sw);
    logic [DW-1:0] want [$];
    int n, beat, cyc;
    bit wrote;
    start = 1;
    if (sw) begin
      we = 1; adr = 0; data = 32'h55; mdl[0] = 32'h55;
    end
    for (int i = 0; i < OC; i++) want.push_back(mdl[i]);
`ifdef DENSE_OUT_ARGMAX_EN
    begin
      int bi = 0;
      for (int i = 1; i < OC; i++) if ($signed(mdl[i]) > $signed(mdl[bi])) bi = i;
      want.push_back(DW'(bi));
    end
`endif
    n = want.size();
    @(negedge clk);
    start = 0; we = 0;
    chk("overrun_clr", overrun, 0);
    beat = 0; cyc = 0; wrote = 0;
    while (beat < n && cyc < 400) begin
      tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (mode == 2) start = ($urandom_range(0, 7) == 0);
      chk("tvalid", tvalid, 1);
      chk("busy", busy, 1);
      chk("tdata", tdata, want[beat]);
      chk("tlast", tlast, beat == n - 1);
      chk("done_low", done, 0);
      if (beat == wr_beat && !wrote) begin
        we = 1; adr = 2; data = 99; wrote = 1;
      end
      if (beat == rst_beat) begin
        rst = 1;
        @(negedge clk);
        rst = 0; we = 0; start = 0; tready = 0;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tdata", tdata, 0);
        for (int i = 0; i < OC; i++) mdl[i] = '0;
        return;
      end
      @(negedge clk);
      we = 0;
      if (tready) beat++;
      cyc++;
    end
    start = 0; we = 0;
    if (cyc >= 400) chk("timeout", 0, 1);
    chk("done", done, 1);
    chk("idle_tvalid", tvalid, 0);
    chk("idle_busy", busy, 0);
    chk("overrun", overrun, wr_beat >= 0);
  endtask
  initial begin
    rst = 1; we = 0; start = 0; tready = 0; adr = 0; data = 0;
    for (int i = 0; i < OC; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_done", done, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    rst = 0;
    for (int i = 0; i < OC; i++) wr(i, 3 * i);
    frame(0, -1, -1, 0);
    frame(1, -1, -1, 0);
    frame(0, 4, -1, 0);
    frame(0, -1, -1, 0);
    for (int i = 0; i < OC; i++) wr(i, $urandom);
    frame(1, -1, 4, 0);
    frame(0, -1, -1, 0);
    for (int i = 0; i < OC; i++) wr(i, $urandom);
    wr(12, 32'hdead);
    wr(15, 32'hbeef);
    frame(2, -1, -1, 0);
    frame(0, -1, -1, 1);
    begin
      int v [OC] = '{-3, 7, 2, 7, 0, -1, 4, 1, 5, 6};
      for (int i = 0; i < OC; i++) wr(i, DW'(v[i]));
    end
    frame(2, -1, -1, 0);
    repeat (6) begin
      repeat ($urandom_range(1, 12)) wr($urandom_range(0, 15), $urandom_range(0, 3) == 0 ? DW'(-$urandom_range(0, 9)) : $urandom);
      frame(2, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, OC - 1)) : -1, -1, 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
